// File: rtl/multdiv_sequencer_pkg.sv
// Shared definitions for the multi-cycle MUL/DIV unit.
// Contents:
//   - operand width and iteration counter width
//   - rstatus register index and exception codes (shared with the ALU exception path)
//   - FSM state encoding
//   - conditional two's-complement negate used for the final sign fix-up
package multdiv_sequencer_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [4:0]       MD_STATUS_REG = 5'd30;
  localparam logic [WIDTH-1:0] MD_MUL_EXC    = 32'd4;
  localparam logic [WIDTH-1:0] MD_DIV_EXC    = 32'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Two's-complement negate of a double-width value when neg is set.
  function automatic logic [2*WIDTH-1:0] cond_negate(input logic [2*WIDTH-1:0] v,
                                                     input logic neg);
    logic [2*WIDTH-1:0] r;
    if (neg) begin
      r = (~v) + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/multdiv_sequencer_if.sv
// Execute/writeback <-> MUL/DIV sequencer connection.
// Signals:
//   start_mult/start_div  issue strobes from execute
//   operand_a/operand_b   signed rs/rt values
//   dest_reg              rd of the issuing instruction
//   flush                 branch/jump squash
//   wb_ready              writeback port free this cycle
//   stall                 freeze upstream pipeline
//   result_valid/result/result_reg/exception  writeback request
// Modports: master = pipeline side, slave = sequencer side.
interface multdiv_sequencer_if;
  import multdiv_sequencer_pkg::*;

  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [4:0]       dest_reg;
  logic             flush;
  logic             wb_ready;
  logic             stall;
  logic             result_valid;
  logic [WIDTH-1:0] result;
  logic [4:0]       result_reg;
  logic             exception;

  modport master (
    output start_mult, start_div, operand_a, operand_b, dest_reg, flush, wb_ready,
    input  stall, result_valid, result, result_reg, exception
  );

  modport slave (
    input  start_mult, start_div, operand_a, operand_b, dest_reg, flush, wb_ready,
    output stall, result_valid, result, result_reg, exception
  );

endinterface

// File: rtl/multdiv_sequencer_datapath.sv
// Iterative radix-2 datapath for signed MUL/DIV on operand magnitudes.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   load          capture operand magnitudes, result sign and mode
//   step          perform one shift-add (mult) or restoring-subtract (div) step
//   mode_div      operation select sampled on load (1 = divide)
//   a, b          signed operands
//   res           signed result as it will be after the current step
//   ovf           multiply result does not fit in WIDTH signed bits
// One 2*WIDTH+1 accumulator serves both ops: {hi, multiplier} for mult,
// {remainder, quotient} for div.
module multdiv_sequencer_datapath
  import multdiv_sequencer_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             mode_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             ovf
);

  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   bmag_q, bmag_d;
  logic               neg_q, neg_d;
  logic               div_q, div_d;

  logic [WIDTH-1:0]   amag_s, bmag_s;
  logic [WIDTH:0]     sum_s, trial_s;
  logic [2*WIDTH:0]   sh_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;

  // Magnitudes; MIN_INT maps to 2^(WIDTH-1), which is exact as unsigned.
  assign amag_s = a[WIDTH-1] ? (~a) + {{(WIDTH-1){1'b0}}, 1'b1} : a;
  assign bmag_s = b[WIDTH-1] ? (~b) + {{(WIDTH-1){1'b0}}, 1'b1} : b;

  // Operand load and per-cycle iteration step.
  always_comb begin
    acc_d   = acc_q;
    bmag_d  = bmag_q;
    neg_d   = neg_q;
    div_d   = div_q;
    sum_s   = acc_q[2*WIDTH:WIDTH];
    sh_s    = {acc_q[2*WIDTH-1:0], 1'b0};
    trial_s = sh_s[2*WIDTH:WIDTH] - {1'b0, bmag_q};
    if (load) begin
      acc_d  = {{(WIDTH+1){1'b0}}, amag_s};
      bmag_d = bmag_s;
      neg_d  = a[WIDTH-1] ^ b[WIDTH-1];
      div_d  = mode_div;
    end else if (step) begin
      if (div_q) begin
        // Restoring division: keep the subtraction only when it stays non-negative.
        if (!trial_s[WIDTH]) begin
          acc_d = {trial_s, sh_s[WIDTH-1:1], 1'b1};
        end else begin
          acc_d = sh_s;
        end
      end else begin
        if (acc_q[0]) begin
          sum_s = acc_q[2*WIDTH:WIDTH] + {1'b0, bmag_q};
        end else begin
          sum_s = acc_q[2*WIDTH:WIDTH];
        end
        acc_d = {1'b0, sum_s, acc_q[WIDTH-1:1]};
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Datapath state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q  <= '0;
      bmag_q <= '0;
      neg_q  <= 1'b0;
      div_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      bmag_q <= bmag_d;
      neg_q  <= neg_d;
      div_q  <= div_d;
    end
  end

  // Sign fix-up on the post-step value so the FSM can capture it on the final step.
  assign prod_s = cond_negate(acc_d[2*WIDTH-1:0], neg_q);
  assign quo_s  = neg_q ? (~acc_d[WIDTH-1:0]) + {{(WIDTH-1){1'b0}}, 1'b1} : acc_d[WIDTH-1:0];
  assign res    = div_q ? quo_s : prod_s[WIDTH-1:0];
  // Product fits only if the upper WIDTH+1 bits are a pure sign extension.
  assign ovf    = !div_q && !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));

endmodule

// File: rtl/multdiv_sequencer.sv
// Multi-cycle MUL/DIV controller for the 5-stage pipeline.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   bus           multdiv_sequencer_if.slave: issue, squash, stall and writeback handshake
// Accepts an op in IDLE, stalls the pipeline while the datapath iterates WIDTH
// steps, then holds the result until writeback accepts it. Multiply overflow
// and divide-by-zero are returned as an rstatus write instead of the result.
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter logic [4:0]       STATUS_REG = MD_STATUS_REG,
  parameter logic [WIDTH-1:0] MUL_EXC    = MD_MUL_EXC,
  parameter logic [WIDTH-1:0] DIV_EXC    = MD_DIV_EXC
)
(
  input  logic                clock,
  input  logic                reset,
  multdiv_sequencer_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       dest_q, dest_d;
  logic             result_valid_q, result_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       result_reg_q, result_reg_d;
  logic             exception_q, exception_d;

  logic             load_s, step_s, mode_div_s;
  logic [WIDTH-1:0] dp_res_s;
  logic             dp_ovf_s;

  multdiv_sequencer_datapath u_datapath (
    .clock    (clock),
    .reset    (reset),
    .load     (load_s),
    .step     (step_s),
    .mode_div (mode_div_s),
    .a        (bus.operand_a),
    .b        (bus.operand_b),
    .res      (dp_res_s),
    .ovf      (dp_ovf_s)
  );

  // Next-state, datapath control and writeback register update.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    dest_d         = dest_q;
    result_valid_d = result_valid_q;
    result_d       = result_q;
    result_reg_d   = result_reg_q;
    exception_d    = exception_q;
    load_s         = 1'b0;
    step_s         = 1'b0;
    mode_div_s     = 1'b0;
    if (bus.flush) begin
      // Squash wins over everything, including a same-cycle issue.
      state_d        = ST_IDLE;
      cnt_d          = '0;
      result_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start_mult) begin
            load_s     = 1'b1;
            mode_div_s = 1'b0;
            dest_d     = bus.dest_reg;
            cnt_d      = '0;
            state_d    = ST_MULT;
          end else if (bus.start_div) begin
            load_s     = 1'b1;
            mode_div_s = 1'b1;
            dest_d     = bus.dest_reg;
            cnt_d      = '0;
            if (bus.operand_b == {WIDTH{1'b0}}) begin
              state_d        = ST_DONE;
              result_valid_d = 1'b1;
              result_d       = DIV_EXC;
              result_reg_d   = STATUS_REG;
              exception_d    = 1'b1;
            end else begin
              state_d = ST_DIV;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MULT, ST_DIV: begin
          step_s = 1'b1;
          cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_d        = ST_DONE;
            cnt_d          = '0;
            result_valid_d = 1'b1;
            result_d       = dp_ovf_s ? MUL_EXC : dp_res_s;
            result_reg_d   = dp_ovf_s ? STATUS_REG : dest_q;
            exception_d    = dp_ovf_s;
          end else begin
            state_d = state_q;
          end
        end
        ST_DONE: begin
          if (bus.wb_ready) begin
            state_d        = ST_IDLE;
            result_valid_d = 1'b0;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d        = ST_IDLE;
          cnt_d          = '0;
          result_valid_d = 1'b0;
        end
      endcase
    end
  end

  // FSM, counter and writeback output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      dest_q         <= 5'd0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      result_reg_q   <= 5'd0;
      exception_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      dest_q         <= dest_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
      result_reg_q   <= result_reg_d;
      exception_q    <= exception_d;
    end
  end

  // Same-cycle freeze on issue so the issuing instruction stays in execute.
  assign bus.stall        = (state_q != ST_IDLE) | bus.start_mult | bus.start_div;
  assign bus.result_valid = result_valid_q;
  assign bus.result       = result_q;
  assign bus.result_reg   = result_reg_q;
  assign bus.exception    = exception_q;

endmodule
